// File: rtl/sample_frame_ctrl_pkg.sv
// Shared types and sizing for the sample-frame controller.
package sample_frame_pkg;

  localparam int SAMPLE_W    = 11;
  localparam int FRAME_DEPTH = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } frame_state_e;

endpackage

// File: rtl/sample_frame_ctrl_if.sv
// Requester, FIFO and downstream frame signals of the controller.
// master = controller side, slave = sources / FIFO / consumer side.
interface sample_frame_ctrl_if
  import sample_frame_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = SAMPLE_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_grant;
  logic                      fifo_push;
  logic [DATA_W-1:0]         fifo_wdata;
  logic                      fifo_ready;
  logic                      fifo_read;
  logic                      frame_valid;
  logic                      frame_ready;
  logic [15:0]               frame_cnt;
  logic                      err;

  modport master (
    input  req_valid, req_data, fifo_ready, frame_ready,
    output req_grant, fifo_push, fifo_wdata, fifo_read, frame_valid, frame_cnt, err
  );

  modport slave (
    output req_valid, req_data, fifo_ready, frame_ready,
    input  req_grant, fifo_push, fifo_wdata, fifo_read, frame_valid, frame_cnt, err
  );

endinterface

// File: rtl/sample_frame_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: scans req from ptr upward and grants the first set bit.
// Zero latency; no state, the caller owns and advances the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_grant
);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_frame_ctrl.sv
// Fills a DEPTH-sample FIFO from round-robin sources, then offers the frame downstream (valid/ready).
// Frame valid 1 cycle after last push; grants resume 1 cycle after accept. SAMPLE_FRAME_CTRL_CHK_EN adds a sticky err checker.
module sample_frame_ctrl
  import sample_frame_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = SAMPLE_W,
  parameter int DEPTH   = FRAME_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  sample_frame_ctrl_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  frame_state_e  state_q, state_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [15:0]   fcnt_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [DATA_W-1:0]  src_dat [NUM_REQ];
  logic               handshake;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    assign src_dat[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .idx       (arb_idx),
    .any_grant (arb_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      ptr_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      ptr_q   <= ptr_d;
      if (handshake) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    ptr_d          = ptr_q;
    handshake      = 1'b0;
    bus.req_grant  = '0;
    bus.fifo_push  = 1'b0;
    bus.fifo_wdata = '0;
    bus.fifo_read  = 1'b0;
    if (!reset) begin
      case (state_q)
        FILL: begin
          if (arb_any) begin
            bus.req_grant  = arb_grant;
            bus.fifo_push  = 1'b1;
            bus.fifo_wdata = src_dat[arb_idx];
            fill_d         = fill_q + 1'b1;
            ptr_d          = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            if (fill_q == CW'(DEPTH - 1)) state_d = FULL;
          end
        end
        FULL: begin
          if (bus.frame_ready) begin
            handshake     = 1'b1;
            bus.fifo_read = 1'b1;
            state_d       = FILL;
            fill_d        = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign bus.frame_valid = (state_q == FULL);
  assign bus.frame_cnt   = fcnt_q;

`ifdef SAMPLE_FRAME_CTRL_CHK_EN
  logic err_q;

  // FIFO full flag must track FULL exactly, and nothing may be pushed into a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (((state_q == FULL) != bus.fifo_ready) || (bus.fifo_push && bus.fifo_ready)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// Self-checking bench: directed vectors plus random traffic against a queue-based frame model.
module tb_sample_frame_ctrl;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 11;
  localparam int DEPTH   = 16;

  logic clk;
  logic reset;

  sample_frame_ctrl_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  sample_frame_ctrl #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int  m_fifo[$];
  int  last_frame[$];
  bit  m_full;
  int  m_ptr;
  int  m_fcnt;
  bit  m_err;
  bit  force_ready;

  // what the DUT showed in the most recent tick
  logic [NUM_REQ-1:0] obs_grant;
  logic               obs_push;
  logic               obs_read;
  logic [DATA_W-1:0]  obs_wdata;

  typedef struct {
    logic [3:0]        valid;
    logic [3:0]        grant;
    logic [DATA_W-1:0] wdata;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_data(input int src, input int val);
    bus.req_data[src*DATA_W +: DATA_W] = DATA_W'(val);
  endtask

  // One clock cycle: compute expectations from the spec rules, compare, advance the model.
  task automatic tick();
    int  g, best, wd;
    bit  push_e, read_e;
    logic fr;
    fr = force_ready || (m_fifo.size() == DEPTH);
    bus.fifo_ready = fr;
    #2;
    g = -1; best = NUM_REQ; wd = 0; push_e = 0; read_e = 0;
    if (!reset) begin
      if (!m_full) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req_valid[i]) begin
            int d;
            d = (i - m_ptr + NUM_REQ) % NUM_REQ;
            if (d < best) begin best = d; g = i; end
          end
        end
        if (g >= 0) begin
          push_e = 1;
          wd = int'(bus.req_data[g*DATA_W +: DATA_W]);
        end
      end else begin
        read_e = bus.frame_ready;
      end
    end
    chk("grant", 32'(bus.req_grant), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("push", 32'(bus.fifo_push), 32'(push_e));
    if (push_e) chk("wdata", 32'(bus.fifo_wdata), 32'(wd));
    chk("read", 32'(bus.fifo_read), 32'(read_e));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_full));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));
    chk("err", 32'(bus.err), 32'(m_err));
    obs_grant = bus.req_grant;
    obs_push  = bus.fifo_push;
    obs_read  = bus.fifo_read;
    obs_wdata = bus.fifo_wdata;
    @(posedge clk);
    if (reset) begin
      m_full = 0; m_ptr = 0; m_fcnt = 0; m_err = 0;
      m_fifo.delete();
    end else begin
`ifdef SAMPLE_FRAME_CTRL_CHK_EN
      if ((m_full != fr) || (push_e && fr)) m_err = 1;
`endif
      if (push_e) begin
        m_fifo.push_back(wd);
        m_ptr = (g + 1) % NUM_REQ;
        if (m_fifo.size() == DEPTH) m_full = 1;
      end
      if (read_e) begin
        last_frame = m_fifo;
        m_fifo.delete();
        m_full = 0;
        m_fcnt = (m_fcnt + 1) % 65536;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int pushes, reads, cyc;
    int kcnt [NUM_REQ];
    logic exp_err;

    tbl[0]  = '{4'b0000, 4'b0000, 11'h000};
    tbl[1]  = '{4'b1111, 4'b0001, 11'h010};
    tbl[2]  = '{4'b1111, 4'b0010, 11'h011};
    tbl[3]  = '{4'b0001, 4'b0001, 11'h010};
    tbl[4]  = '{4'b1001, 4'b1000, 11'h013};
    tbl[5]  = '{4'b1001, 4'b0001, 11'h010};
    tbl[6]  = '{4'b0100, 4'b0100, 11'h012};
    tbl[7]  = '{4'b0110, 4'b0010, 11'h011};
    tbl[8]  = '{4'b1010, 4'b1000, 11'h013};
    tbl[9]  = '{4'b0000, 4'b0000, 11'h000};
    tbl[10] = '{4'b1100, 4'b0100, 11'h012};
    tbl[11] = '{4'b1100, 4'b1000, 11'h013};

    reset = 1'b1;
    force_ready = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.frame_ready = 1'b0;
    bus.fifo_ready = 1'b0;
    m_full = 0; m_ptr = 0; m_fcnt = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 1'b0;

    // reset state
    #2;
    chk("rst_grant", 32'(bus.req_grant), 0);
    chk("rst_push", 32'(bus.fifo_push), 0);
    chk("rst_wdata", 32'(bus.fifo_wdata), 0);
    chk("rst_read", 32'(bus.fifo_read), 0);
    chk("rst_fv", 32'(bus.frame_valid), 0);
    chk("rst_fcnt", 32'(bus.frame_cnt), 0);
    chk("rst_err", 32'(bus.err), 0);
    #1;

    // arbitration table from pointer 0
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 'h10 + i);
    for (int t = 0; t < 12; t++) begin
      bus.req_valid = tbl[t].valid;
      tick();
      chk("tbl_grant", 32'(obs_grant), 32'(tbl[t].grant));
      if (tbl[t].grant != 0) chk("tbl_wdata", 32'(obs_wdata), 32'(tbl[t].wdata));
    end

    // all sources valid, distinct data, downstream stalls 10 cycles
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin kcnt[i] = 0; set_data(i, 'h100 * i); end
    bus.req_valid = '1;
    pushes = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk("rot_grant", 32'(obs_grant), 32'd1 << (c % 4));
      pushes += int'(obs_push);
      for (int i = 0; i < NUM_REQ; i++)
        if (obs_grant[i]) begin kcnt[i]++; set_data(i, 'h100 * i + kcnt[i]); end
      if (c < 15) chk("fv_early", 32'(bus.frame_valid), 0);
    end
    chk("push_16", 32'(pushes), 16);
    chk("fv_cycle17", 32'(bus.frame_valid), 1);
    pushes = 0; reads = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      pushes += int'(obs_push);
      reads  += int'(obs_read);
    end
    chk("stall_push", 32'(pushes), 0);
    chk("stall_read", 32'(reads), 0);
    chk("stall_fv", 32'(bus.frame_valid), 1);
    bus.frame_ready = 1'b1;
    tick();
    chk("hs_read", 32'(obs_read), 1);
    chk("hs_fcnt", 32'(bus.frame_cnt), 1);
    chk("frame_len", 32'(last_frame.size()), 16);
    for (int i = 0; i < last_frame.size(); i++)
      chk("frame_data", 32'(last_frame[i]), 32'('h100 * (i % 4) + i / 4));
    tick();
    chk("resume_push", 32'(obs_push), 1);
    chk("resume_noread", 32'(obs_read), 0);

    // only source 2 requests
    do_reset();
    bus.req_valid = 4'b0100;
    set_data(2, 'h2AA);
    pushes = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk("src2_grant", 32'(obs_grant), 32'h4);
      pushes += int'(obs_push);
    end
    chk("src2_push", 32'(pushes), 16);
    tick();
    chk("src2_read", 32'(obs_read), 1);
    bus.req_valid = 4'b1011;
    tick();
    chk("ptr_wrap3", 32'(obs_grant), 32'h8);

    // sparse traffic, one request every third cycle
    do_reset();
    bus.frame_ready = 1'b1;
    pushes = 0; reads = 0;
    for (int c = 0; c < 48; c++) begin
      bus.req_valid = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      tick();
      pushes += int'(obs_push);
      reads  += int'(obs_read);
      chk("push_read_excl", 32'(obs_push & obs_read), 0);
    end
    chk("sparse_push", 32'(pushes), 16);
    chk("sparse_read", 32'(reads), 1);
    chk("sparse_fcnt", 32'(bus.frame_cnt), 1);

    // reset in the middle of a frame
    do_reset();
    bus.frame_ready = 1'b0;
    bus.req_valid = '1;
    repeat (9) tick();
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    reset = 1'b0;
    #2;
    chk("mid_rst_grant", 32'(bus.req_grant), 0);
    chk("mid_rst_push", 32'(bus.fifo_push), 0);
    chk("mid_rst_fv", 32'(bus.frame_valid), 0);
    chk("mid_rst_fcnt", 32'(bus.frame_cnt), 0);
    #1;
    bus.req_valid = '1;
    pushes = 0; cyc = 0;
    while (!bus.frame_valid && cyc < 40) begin
      tick();
      pushes += int'(obs_push);
      cyc++;
    end
    chk("fresh_fv", 32'(bus.frame_valid), 1);
    chk("fresh_push", 32'(pushes), 16);

    // full flag asserted while still filling
    do_reset();
    bus.req_valid = '0;
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
`ifdef SAMPLE_FRAME_CTRL_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    chk("err_set", 32'(bus.err), 32'(exp_err));
    repeat (5) tick();
    chk("err_sticky", 32'(bus.err), 32'(exp_err));
    do_reset();
    chk("err_clear", 32'(bus.err), 0);

    // random traffic
    bus.req_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req_valid[i] || obs_grant[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          set_data(i, int'($urandom_range(0, 2047)));
        end
      bus.frame_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sample_frame_ctrl.md
Name: sample_frame_ctrl

Overview:
- Sequences the 16-entry sample-collection FIFO (11-bit samples, 176-bit parallel frame out).
- Shares the FIFO push port between NUM_REQ sample sources with a round-robin arbiter.
- Counts fills and presents each complete frame downstream with a valid/ready handshake.
- Issues the FIFO read pulse that clears the frame once it is accepted.

Parameters:
- NUM_REQ, 4, number of sample requesters (2..8)
- DATA_W, 11, sample width
- DEPTH, 16, samples per frame; must equal the FIFO depth

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-source sample available
- req_data  in  NUM_REQ*DATA_W  per-source sample; source i occupies bits [i*DATA_W +: DATA_W]
- req_grant  out  NUM_REQ  one-hot; sample i is consumed when req_valid[i] & req_grant[i]
- fifo_push  out  1  to FIFO push
- fifo_wdata  out  DATA_W  to FIFO wdata
- fifo_ready  in  1  FIFO full indication (count == DEPTH)
- fifo_read  out  1  to FIFO read; clears the frame
- frame_valid  out  1  complete frame available downstream
- frame_ready  in  1  downstream accepts the frame
- frame_cnt  out  16  frames delivered, wraps modulo 2^16
- err  out  1  sticky consistency error (see Optional Feature)

Behaviour:
- Reset (sync, active-high; dominates all other inputs):
  - state=FILL, fill_cnt=0, rr_ptr=0, frame_cnt=0, err=0.
  - All outputs low, except fifo_wdata=0.
- FSM states: FILL, FULL.
- FILL:
  - Arbiter scans req_valid starting at rr_ptr and grants the first valid source. Grant is combinational, at most one per cycle.
  - On a grant: fifo_push=1 and fifo_wdata=req_data of the granted source, same cycle. fill_cnt increments. rr_ptr <= granted index + 1, wrapping NUM_REQ-1 -> 0.
  - If no source is valid: no grant, rr_ptr holds.
  - When a push occurs with fill_cnt==DEPTH-1: next state FULL, fill_cnt <= DEPTH.
- FULL:
  - req_grant=0 and fifo_push=0.
  - frame_valid=1, registered; first high the cycle after the last push.
  - fifo_read = frame_valid & frame_ready, combinational.
  - On the handshake: next state FILL, fill_cnt <= 0, frame_cnt increments.
  - Granting resumes the cycle after the handshake, so push and read never coincide.
- frame_valid holds until accepted. It never drops without a handshake.
- Latency:
  - Last push to frame_valid: 1 cycle.
  - Handshake to first new grant: 1 cycle.
  - Minimum frame period: DEPTH+1 cycles.
- Req_data is sampled only in the cycle the grant occurs. Sources must hold data while valid.
- Reset mid-frame: the controller restarts at FILL with an empty count. The FIFO shares the same reset, so both are cleared together.

Optional Feature:
- Macro: SAMPLE_FRAME_CTRL_CHK_EN.
- When defined:
  - Each cycle, compares (state==FULL) against fifo_ready, and checks for a push attempted while fifo_ready=1.
  - Any mismatch sets err=1. err is sticky until reset.
  - The controller's own sequencing is unchanged.
- When undefined: err is tied to 0 and no checker logic is built.

Decomposition:
- Package sample_frame_pkg:
  - SAMPLE_W=11, FRAME_DEPTH=16.
  - typedef sample_t (logic [SAMPLE_W-1:0]).
  - typedef enum frame_state_e {FILL, FULL}.
- Sub-module rr_arbiter:
  - Parameterised on N.
  - Inputs: req vector, ptr. Outputs: one-hot grant, granted index, any_grant.
  - Purely combinational.
- The pointer register stays in the parent.

Test Plan:
- All 4 sources valid continuously, distinct data (src i sends 0x100*i+k):
  - Grants rotate 0,1,2,3,0,… and 16 pushes in 16 cycles.
  - frame_valid rises in cycle 17.
  - Frame holds src0,src1,src2,src3 repeated 4 times.
- Only source 2 valid:
  - Grant 2 every cycle; 16 pushes.
  - rr_ptr wraps to 3 after each grant; no grants to idle sources.
- frame_ready held low 10 cycles after frame_valid:
  - frame_valid stays 1, no pushes, fifo_read=0.
  - Raise frame_ready: exactly one fifo_read pulse, frame_cnt 0->1, grants resume next cycle.
- Sparse traffic (one valid every 3 cycles):
  - fill_cnt reaches 16 after 48 cycles.
  - No push while FULL; no push in the fifo_read cycle.
- Reset asserted when fill_cnt=9:
  - Next cycle all outputs 0, fill_cnt=0.
  - The following frame needs 16 fresh pushes.
- With SAMPLE_FRAME_CTRL_CHK_EN, force fifo_ready=1 during FILL:
  - err=1 the next cycle and stays 1 until reset.
  - Without the macro, err stays 0.
